sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 122 ++++++++++++
 tb/tb_sha256_padder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// Streams message bytes into 512-bit SHA-256 blocks, appending the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, with valid/ready on both sides.
module sha256_padder #(
   parameter int unsigned LEN_W = 32
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic [7:0]   byte_i,
   input  logic         byte_valid_i,
   input  logic         byte_last_i,
   input  logic         byte_empty_i,
   output logic         byte_ready_o,
   output logic [511:0] blk_o,
   output logic         blk_valid_o,
   output logic         blk_last_o,
   input  logic         blk_ready_i
);

   typedef enum logic [1:0] {
      ACCUM,
      EMIT_DATA,
      EMIT_PAD1,
      EMIT_PAD2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [511:0]       data;
   logic [5:0]         idx;
   logic [LEN_W-1:0]   count;
   logic               full_last;
   logic               take_byte;
   logic               done;
   logic [8:0]         byte_pos;
   logic [63:0]        bit_len;
   logic [511:0]       marker;

   assign byte_pos  = {6'd63 - idx, 3'b000};
   assign bit_len   = 64'(count) << 3;
   assign marker    = 512'h80 << byte_pos;
   assign take_byte = (state == ACCUM) && byte_valid_i && !byte_empty_i;
   assign done      = blk_valid_o && blk_ready_i && blk_last_o;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // Buffer bytes past idx are kept zero, so padding only needs to OR in the marker.
   always_comb begin
      state_next   = state;
      byte_ready_o = 1'b0;
      blk_valid_o  = 1'b0;
      blk_last_o   = 1'b0;
      blk_o        = '0;
      case (state)
         ACCUM: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) begin
               if (!byte_empty_i && idx == 6'd63) begin
                  state_next = EMIT_DATA;
               end else if (byte_last_i) begin
                  state_next = EMIT_PAD1;
               end
            end
         end
         EMIT_DATA: begin
            blk_valid_o = 1'b1;
            blk_o       = data;
            if (blk_ready_i) begin
               state_next = full_last ? EMIT_PAD2 : ACCUM;
            end
         end
         EMIT_PAD1: begin
            blk_valid_o = 1'b1;
            blk_o       = data | marker;
            if (idx <= 6'd55) begin
               blk_last_o  = 1'b1;
               blk_o[63:0] = bit_len;
            end
            if (blk_ready_i) begin
               state_next = (idx <= 6'd55) ? ACCUM : EMIT_PAD2;
            end
         end
         EMIT_PAD2: begin
            blk_valid_o     = 1'b1;
            blk_last_o      = 1'b1;
            blk_o[511:504]  = full_last ? 8'h80 : 8'h00;
            blk_o[63:0]     = bit_len;
            if (blk_ready_i) begin
               state_next = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // full_last remembers that the message ended exactly on a block boundary.
   always_ff @(posedge clk_i) begin
      if (!rstn_i || done) begin
         data      <= '0;
         idx       <= '0;
         count     <= '0;
         full_last <= 1'b0;
      end else if (take_byte) begin
         data[byte_pos +: 8] <= byte_i;
         idx                 <= idx + 6'd1;
         count               <= count + LEN_W'(1);
         if (idx == 6'd63) begin
            full_last <= byte_last_i;
         end
      end else if (state == EMIT_DATA && blk_ready_i) begin
         data <= '0;
      end
   end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed and random messages compared against a
// standard SHA-256 padding model, with random back-pressure and resets.
module tb_sha256_padder;

   typedef struct {
      logic [7:0] data;
      bit         last;
      bit         empty;
   } beat_t;

   logic         clk_i;
   logic         rstn_i;
   logic [7:0]   byte_i;
   logic         byte_valid_i;
   logic         byte_last_i;
   logic         byte_empty_i;
   logic         byte_ready_o;
   logic [511:0] blk_o;
   logic         blk_valid_o;
   logic         blk_last_o;
   logic         blk_ready_i;

   int           vectors;
   int           miscompares;
   logic [7:0]   msg_q[$];
   beat_t        beats[$];
   logic [511:0] exp_blk[$];
   bit           exp_last[$];

   localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};

   sha256_padder #(.LEN_W(32)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_last_i  (byte_last_i),
      .byte_empty_i (byte_empty_i),
      .byte_ready_o (byte_ready_o),
      .blk_o        (blk_o),
      .blk_valid_o  (blk_valid_o),
      .blk_last_o   (blk_last_o),
      .blk_ready_i  (blk_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Textbook padding: data, 0x80, zeros to 56 mod 64, then 64-bit bit length.
   task automatic model_blocks();
      logic [7:0]   p[$];
      logic [63:0]  bit_len;
      logic [511:0] b;
      int           nblk;
      p = msg_q;
      bit_len = 64'(msg_q.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bit_len[8*i +: 8]);
      nblk = p.size() / 64;
      for (int k = 0; k < nblk; k++) begin
         for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
         exp_blk.push_back(b);
         exp_last.push_back(k == nblk - 1);
      end
   endtask

   task automatic make_beats(input bit term_empty, input bit sprinkle);
      beat_t bt;
      bit    sep;
      sep = term_empty || (msg_q.size() == 0);
      for (int i = 0; i < msg_q.size(); i++) begin
         if (sprinkle && $urandom_range(0, 5) == 0) begin
            bt.data = 8'($urandom); bt.last = 1'b0; bt.empty = 1'b1;
            beats.push_back(bt);
         end
         bt.data = msg_q[i]; bt.last = !sep && (i == msg_q.size() - 1); bt.empty = 1'b0;
         beats.push_back(bt);
      end
      if (sep) begin
         bt.data = 8'($urandom); bt.last = 1'b1; bt.empty = 1'b1;
         beats.push_back(bt);
      end
   endtask

   task automatic fill_msg(input int n, input logic [7:0] val);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(val);
   endtask

   task automatic apply_stimulus(input bit stall);
      int cycles;
      int stall_cnt;
      bit want_valid;
      cycles = 0; stall_cnt = 0; want_valid = 1'b0;
      while ((beats.size() != 0 || exp_blk.size() != 0) && cycles < 5000) begin
         cycles++;
         if (beats.size() != 0 && $urandom_range(0, 3) != 0) begin
            byte_valid_i = 1'b1;
            byte_i       = beats[0].data;
            byte_last_i  = beats[0].last;
            byte_empty_i = beats[0].empty;
         end else begin
            byte_valid_i = 1'b0;
            byte_i       = 8'($urandom);
            byte_last_i  = 1'($urandom);
            byte_empty_i = 1'($urandom);
         end
         blk_ready_i = stall ? (stall_cnt >= 5) : ($urandom_range(0, 2) != 0);
         @(negedge clk_i);
         if (want_valid) check_output("latency_valid", blk_valid_o, 1'b1);
         want_valid = 1'b0;
         check_output("ready_vs_valid", byte_ready_o, !blk_valid_o);
         if (byte_valid_i && byte_ready_o) begin
            want_valid = beats[0].last;
            beats.pop_front();
         end
         if (blk_valid_o) begin
            if (stall) stall_cnt++;
            if (exp_blk.size() == 0) begin
               check_output("unexpected_block", blk_valid_o, 1'b0);
            end else begin
               check_output("blk_data", blk_o, exp_blk[0]);
               check_output("blk_last", blk_last_o, exp_last[0]);
               if (blk_ready_i) begin
                  exp_blk.pop_front();
                  exp_last.pop_front();
               end
            end
         end
         @(posedge clk_i); #1;
      end
      check_output("drained", 512'(beats.size() + exp_blk.size()), 512'd0);
      beats.delete(); exp_blk.delete(); exp_last.delete();
      byte_valid_i = 1'b0;
      blk_ready_i  = 1'b0;
      check_output("idle_ready", byte_ready_o, 1'b1);
      check_output("idle_valid", blk_valid_o, 1'b0);
   endtask

   task automatic feed_raw(input int n, input bit last_on_final);
      for (int i = 0; i < n; i++) begin
         byte_valid_i = 1'b1;
         byte_i       = 8'($urandom);
         byte_last_i  = last_on_final && (i == n - 1);
         byte_empty_i = 1'b0;
         @(posedge clk_i); #1;
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic pulse_reset_and_check(input string tag);
      rstn_i = 1'b0;
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      blk_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_output({tag, "_no_valid"}, blk_valid_o, 1'b0);
         check_output({tag, "_ready"}, byte_ready_o, 1'b1);
      end
      @(posedge clk_i); #1;
      blk_ready_i = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rstn_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0; byte_last_i = 1'b0;
      byte_empty_i = 1'b0; blk_ready_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check_output("reset_valid", blk_valid_o, 1'b0);
      check_output("reset_last", blk_last_o, 1'b0);
      check_output("reset_blk", blk_o, 512'd0);
      rstn_i = 1'b1;
      @(posedge clk_i); #1;
      check_output("reset_ready", byte_ready_o, 1'b1);

      $display("[TB] empty and abc messages");
      msg_q.delete(); make_beats(1'b1, 1'b0);
      exp_blk.push_back(EMPTY_BLK); exp_last.push_back(1'b1);
      apply_stimulus(1'b0);
      msg_q = '{8'h61, 8'h62, 8'h63}; make_beats(1'b0, 1'b0);
      exp_blk.push_back(ABC_BLK); exp_last.push_back(1'b1);
      apply_stimulus(1'b0);

      $display("[TB] length boundaries");
      fill_msg(55, 8'h00); make_beats(1'b0, 1'b0); model_blocks(); apply_stimulus(1'b0);
      fill_msg(56, 8'h61); make_beats(1'b0, 1'b0); model_blocks(); apply_stimulus(1'b0);
      fill_msg(64, 8'h61); make_beats(1'b0, 1'b0); model_blocks(); apply_stimulus(1'b0);
      fill_msg(64, 8'h61); make_beats(1'b1, 1'b1); model_blocks(); apply_stimulus(1'b0);
      fill_msg(65, 8'h61); make_beats(1'b0, 1'b0); model_blocks(); apply_stimulus(1'b0);

      $display("[TB] back-pressure with a queued follow-on message");
      msg_q = '{8'h61, 8'h62, 8'h63}; make_beats(1'b0, 1'b0);
      exp_blk.push_back(ABC_BLK); exp_last.push_back(1'b1);
      msg_q.delete(); make_beats(1'b1, 1'b0);
      exp_blk.push_back(EMPTY_BLK); exp_last.push_back(1'b1);
      apply_stimulus(1'b1);

      $display("[TB] reset mid-message and mid-emission");
      blk_ready_i = 1'b1;
      feed_raw(10, 1'b0);
      pulse_reset_and_check("rst_msg");
      msg_q = '{8'h61, 8'h62, 8'h63}; make_beats(1'b0, 1'b0);
      exp_blk.push_back(ABC_BLK); exp_last.push_back(1'b1);
      apply_stimulus(1'b0);
      blk_ready_i = 1'b0;
      feed_raw(20, 1'b1);
      @(negedge clk_i);
      check_output("held_block", blk_valid_o, 1'b1);
      @(posedge clk_i); #1;
      pulse_reset_and_check("rst_emit");
      msg_q.delete(); make_beats(1'b1, 1'b0);
      exp_blk.push_back(EMPTY_BLK); exp_last.push_back(1'b1);
      apply_stimulus(1'b0);

      $display("[TB] random messages");
      for (int t = 0; t < 25; t++) begin
         msg_q.delete();
         for (int i = 0, n = $urandom_range(0, 150); i < n; i++) msg_q.push_back(8'($urandom));
         make_beats(1'($urandom), 1'b1);
         model_blocks();
         apply_stimulus(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
